// File: rtl/icache_refill_bridge_if.sv
// Bus bundle between the I-cache refill port, the refill bridge and the pipelined memory port.
// master = the bridge, slave = the cache/memory side that drives requests and responses.
interface icache_refill_bridge_if #(
    parameter int BLK_SIZE = 128
);
    logic                dev_rrdy;
    logic [3:0]          cpu_ren;
    logic [31:0]         cpu_raddr;
    logic                dev_rvalid;
    logic [BLK_SIZE-1:0] dev_rdata;
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic                mem_gnt;
    logic                mem_rvalid;
    logic [31:0]         mem_rdata;

    modport master (
        output dev_rrdy, dev_rvalid, dev_rdata, mem_req, mem_addr,
        input  cpu_ren, cpu_raddr, mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  dev_rrdy, dev_rvalid, dev_rdata, mem_req, mem_addr,
        output cpu_ren, cpu_raddr, mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/icache_refill_bridge.sv
// Turns one cache block read into BLK_WORDS pipelined word reads and returns the assembled line.
//
// state | meaning
// IDLE  | ready for a block read, dev_rrdy=1
// BURST | issuing word requests and collecting in-order responses
// RESP  | one-cycle dev_rvalid pulse, line held on dev_rdata
module icache_refill_bridge #(
    parameter int BLK_SIZE  = 128,
    parameter int BLK_WORDS = BLK_SIZE / 32
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,
    icache_refill_bridge_if.master bus
);
    localparam int CNT_W = $clog2(BLK_WORDS) + 1;

    typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

    state_t              state_q, state_d;
    logic [31:0]         base_q, base_d;
    logic [CNT_W-1:0]    iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;
    logic [BLK_SIZE-1:0] rdata_q, rdata_d;

    logic        req_act;
    logic        issue;
    logic        capture;
    logic [31:0] addr_off;

    assign req_act  = (state_q == BURST) && (iss_cnt_q < CNT_W'(BLK_WORDS));
    assign issue    = req_act && bus.mem_gnt;
    // A response is only owed for a word already granted, or for the one granted this very cycle.
    assign capture  = (state_q == BURST) && bus.mem_rvalid &&
                      ((ret_cnt_q < iss_cnt_q) || issue);
    assign addr_off = 32'({iss_cnt_q, 2'b00});

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q   <= IDLE;
            base_q    <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            iss_cnt_q <= iss_cnt_d;
            ret_cnt_q <= ret_cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        iss_cnt_d = iss_cnt_q;
        ret_cnt_d = ret_cnt_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (|bus.cpu_ren) begin
                    base_d    = {bus.cpu_raddr[31:4], 4'h0};
                    iss_cnt_d = '0;
                    ret_cnt_d = '0;
                    state_d   = BURST;
                end
            end
            BURST: begin
                if (issue) begin
                    iss_cnt_d = iss_cnt_q + 1'b1;
                end
                if (capture) begin
                    // Word 0 lands in the most significant slot.
                    for (int k = 0; k < BLK_WORDS; k++) begin
                        if (ret_cnt_q == CNT_W'(k)) begin
                            rdata_d[BLK_SIZE-1-32*k -: 32] = bus.mem_rdata;
                        end
                    end
                    ret_cnt_d = ret_cnt_q + 1'b1;
                    if (ret_cnt_q == CNT_W'(BLK_WORDS - 1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dev_rrdy   = (state_q == IDLE);
    assign bus.dev_rvalid = (state_q == RESP);
    assign bus.dev_rdata  = rdata_q;
    assign bus.mem_req    = req_act;
    assign bus.mem_addr   = base_q + addr_off;
endmodule

// File: tb/tb_icache_refill_bridge.sv
// Randomized bench for icache_refill_bridge: a word-level memory model plus a line-level
// expectation of addresses, busy window, pulse latency and assembled data.
module tb_icache_refill_bridge;
    localparam int BLK_SIZE = 128;
    localparam int W        = 4;

    logic cpu_clk = 1'b0;
    logic cpu_rstn;
    always #5 cpu_clk = ~cpu_clk;

    icache_refill_bridge_if #(.BLK_SIZE(BLK_SIZE)) bus ();

    icache_refill_bridge #(.BLK_SIZE(BLK_SIZE), .BLK_WORDS(W)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .bus      (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] last_line;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge cpu_clk);
            chk("idle_rrdy", bus.dev_rrdy, 1'b1);
            chk("idle_rvalid", bus.dev_rvalid, 1'b0);
            chk("idle_mem_req", bus.mem_req, 1'b0);
            chk("idle_rdata", bus.dev_rdata, last_line);
            bus.cpu_ren    = 4'h0;
            bus.mem_gnt    = 1'($urandom_range(0, 1));
            bus.mem_rvalid = 1'($urandom_range(0, 1));
            bus.mem_rdata  = $urandom;
        end
    endtask

    // gnt_pct: grant probability; lat_mode 0=same-cycle data, 1=next-cycle data, 2=random
    task automatic run_burst(input logic [31:0] addr, input int gnt_pct, input int lat_mode,
                             input int stall_word, input int stall_len, input bit ren_mid,
                             input int exp_lat, input bit seq_data);
        logic [31:0]  base;
        logic [31:0]  pend[$];
        logic [127:0] exp_line;
        logic [31:0]  rd, wd;
        int           ngr, nret, c, stall_left;
        bit           gnt, rv, seen, exp_req;

        base = {addr[31:4], 4'h0};
        ngr = 0; nret = 0; stall_left = stall_len; seen = 0; exp_line = '0;
        @(negedge cpu_clk);
        chk("rrdy_before_req", bus.dev_rrdy, 1'b1);
        bus.cpu_ren    = 4'($urandom_range(1, 15));
        bus.cpu_raddr  = addr;
        bus.mem_gnt    = 1'($urandom_range(0, 1));
        bus.mem_rvalid = 1'($urandom_range(0, 1));
        bus.mem_rdata  = $urandom;
        for (c = 1; c <= 80; c++) begin
            @(negedge cpu_clk);
            bus.cpu_ren    = 4'h0;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (bus.dev_rvalid === 1'b1) begin
                seen = 1;
                break;
            end
            chk("rrdy_busy", bus.dev_rrdy, 1'b0);
            exp_req = (ngr < W);
            chk("mem_req", bus.mem_req, exp_req);
            if (exp_req) chk("mem_addr", bus.mem_addr, base + 32'(4 * ngr));

            if (exp_req && stall_left > 0 && ngr == stall_word) begin
                gnt = 0;
                stall_left--;
            end else begin
                gnt = ($urandom_range(0, 99) < gnt_pct);
            end
            rv = 0;
            rd = $urandom;
            if (pend.size() > 0 && (lat_mode != 2 || $urandom_range(0, 1) == 1)) begin
                rv = 1;
                rd = pend.pop_front();
                exp_line[127-32*nret -: 32] = rd;
                nret++;
            end
            wd = seq_data ? 32'hA0 + 32'(ngr) : $urandom;
            if (gnt && exp_req) begin
                if (!rv && pend.size() == 0 &&
                    (lat_mode == 0 || (lat_mode == 2 && $urandom_range(0, 1) == 1))) begin
                    rv = 1;
                    rd = wd;
                    exp_line[127-32*nret -: 32] = wd;
                    nret++;
                end else begin
                    pend.push_back(wd);
                end
                ngr++;
            end else if (!rv && pend.size() == 0 && $urandom_range(0, 3) == 0) begin
                rv = 1;
            end
            if (ren_mid && $urandom_range(0, 1) == 1) bus.cpu_ren = 4'($urandom_range(1, 15));
            bus.mem_gnt    = gnt;
            bus.mem_rvalid = rv;
            bus.mem_rdata  = rd;
        end
        chk("burst_done", 1'(seen), 1'b1);
        if (seen) begin
            chk("dev_rdata", bus.dev_rdata, exp_line);
            chk("pulse_rrdy", bus.dev_rrdy, 1'b0);
            if (exp_lat > 0) chk("latency", 32'(c), 32'(exp_lat));
            last_line = exp_line;
        end
    endtask

    initial begin
        cpu_rstn       = 1'b0;
        bus.cpu_ren    = 4'h0;
        bus.cpu_raddr  = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        last_line      = '0;
        repeat (3) @(negedge cpu_clk);
        chk("rst_rrdy", bus.dev_rrdy, 1'b1);
        chk("rst_rvalid", bus.dev_rvalid, 1'b0);
        chk("rst_rdata", bus.dev_rdata, 128'h0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        cpu_rstn = 1'b1;
        idle_cycles(2);

        // zero-wait memory, data one cycle after grant
        run_burst(32'h1C00_0024, 100, 1, -1, 0, 0, 6, 1);
        idle_cycles(1);
        chk("t1_line", bus.dev_rdata, 128'h000000A0_000000A1_000000A2_000000A3);

        // grant withheld three cycles on the second word
        run_burst(32'h0000_4A5C, 100, 1, 1, 3, 0, 9, 0);
        idle_cycles(1);

        // same-cycle grant and data
        run_burst(32'h8765_4321, 100, 0, -1, 0, 0, 5, 0);
        idle_cycles(1);

        // requests re-presented mid-burst, spurious responses afterwards
        run_burst(32'h3000_0100, 100, 2, -1, 0, 1, 0, 0);
        idle_cycles(5);

        // reset after two words have been captured
        @(negedge cpu_clk);
        bus.cpu_ren = 4'hF; bus.cpu_raddr = 32'h2000_0010;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        @(negedge cpu_clk);
        bus.cpu_ren = 4'h0; bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0;
        @(negedge cpu_clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11;
        @(negedge cpu_clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h22;
        @(negedge cpu_clk);
        chk("partial_rdata", bus.dev_rdata[127:64], 64'h00000011_00000022);
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        cpu_rstn = 1'b0;
        #1;
        chk("mid_rst_rrdy", bus.dev_rrdy, 1'b1);
        chk("mid_rst_rvalid", bus.dev_rvalid, 1'b0);
        chk("mid_rst_rdata", bus.dev_rdata, 128'h0);
        chk("mid_rst_mem_req", bus.mem_req, 1'b0);
        chk("mid_rst_mem_addr", bus.mem_addr, 32'h0);
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_0033;
        @(negedge cpu_clk);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBEEF_0044;
        last_line = '0;
        idle_cycles(3);
        run_burst(32'h2000_0010, 80, 2, -1, 0, 0, 0, 0);
        idle_cycles(1);

        // address wrap at the top of the space
        run_burst(32'hFFFF_FFF0, 70, 2, -1, 0, 0, 0, 0);
        idle_cycles(1);
        run_burst(32'hFFFF_FFFF, 100, 1, -1, 0, 0, 6, 0);
        idle_cycles(1);

        for (int i = 0; i < 25; i++) begin
            run_burst($urandom, 50, 2, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), 0, 0);
            idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
